// File: rtl/step_if_pkg.sv
// Shared definitions for the step/dir receive path: FSM encoding, bus widths
// and the direction polarity constant.
package step_if_pkg;

  localparam int X_W      = 64;
  localparam int PERIOD_W = 32;
  localparam int IDLE_W   = 16;

  // dir pin level that means "move in the positive direction"
  localparam logic DIR_POS = 1'b1;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } step_state_t;

  // +1 for the positive direction, -1 (all ones) otherwise
  function automatic logic [X_W-1:0] step_delta(input logic d);
    return (d == DIR_POS) ? X_W'(1) : {X_W{1'b1}};
  endfunction

endpackage

// File: rtl/step_dir_decoder_if.sv
// Signal bundle between the step/dir decoder and its host logic.
// slave = decoder side, master = host/driver side.
interface step_dir_decoder_if;
  import step_if_pkg::*;

  // Strobe semantics: load and clear_err are single-cycle pulses acted on in the
  // cycle they are high; step_seen is a single-cycle pulse. There is no
  // back-pressure anywhere on this bundle.
  logic                       step_in;
  logic                       dir_in;
  logic                       load;
  logic signed [X_W-1:0]      x_val;
  logic                       clear_err;

  logic signed [X_W-1:0]      x;
  logic                       dir;
  logic                       step_seen;
  logic                       err_width;
  logic                       err_dir;
  logic                       stopped;
  logic [PERIOD_W-1:0]        period;
  logic                       period_valid;
  step_state_t                fsm_state;

  modport slave (
    input  step_in, dir_in, load, x_val, clear_err,
    output x, dir, step_seen, err_width, err_dir, stopped,
           period, period_valid, fsm_state
  );

  modport master (
    output step_in, dir_in, load, x_val, clear_err,
    input  x, dir, step_seen, err_width, err_dir, stopped,
           period, period_valid, fsm_state
  );

endinterface

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for asynchronous pins; both flops clear to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: synchronizes the pins, counts step rising edges into a
// signed 64-bit position and flags timing errors. Optional STEP_PERIOD_EN adds
// a step-to-step period measurement.
module step_dir_decoder
  import step_if_pkg::*;
#(
  parameter int MIN_HIGH     = 4,
  parameter int DIR_SETUP    = 8,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  step_dir_decoder_if.slave  bus
);

  localparam int HI_W = $clog2(MIN_HIGH + 2);
  localparam int DS_W = $clog2(DIR_SETUP + 2);
  localparam logic [HI_W-1:0]   HI_MAX   = HI_W'(MIN_HIGH);
  localparam logic [DS_W-1:0]   DS_MAX   = DS_W'(DIR_SETUP);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  logic s_step, s_dir;
  logic s_step_d, s_dir_d;
  logic rise, dir_change;

  sync_2ff u_sync_step (.clk(clk), .reset(reset), .d(bus.step_in), .q(s_step));
  sync_2ff u_sync_dir  (.clk(clk), .reset(reset), .d(bus.dir_in),  .q(s_dir));

  assign rise       = s_step & ~s_step_d;
  assign dir_change = s_dir ^ s_dir_d;

  // The synchronizer outputs are forced low by reset, so ARM ignores them
  // until real pin samples have reached s_step (arm_cnt == 2).
  logic [1:0]        arm_cnt;
  step_state_t       state, state_nxt;
  logic [HI_W-1:0]   hi_cnt, hi_cnt_nxt;
  logic              count;
  logic              width_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_ARM;
      hi_cnt <= '0;
    end else begin
      state  <= state_nxt;
      hi_cnt <= hi_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hi_cnt_nxt = hi_cnt;
    count      = 1'b0;
    width_bad  = 1'b0;
    case (state)
      ST_ARM: begin
        if (arm_cnt == 2'd2 && !s_step) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (rise) begin
          count      = 1'b1;
          state_nxt  = ST_HIGH;
          hi_cnt_nxt = HI_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s_step) begin
          state_nxt = ST_LOW;
          width_bad = (hi_cnt < HI_MAX);
        end else if (hi_cnt < HI_MAX) begin
          hi_cnt_nxt = hi_cnt + HI_W'(1);
        end
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  // dir_stable_now is the number of cycles s_dir has held its current value,
  // so a dir change landing in the same cycle as the rise reads as zero.
  logic [DS_W-1:0]       dir_stable, dir_stable_now;
  logic                  dir_bad;
  logic signed [X_W-1:0] x_q, x_base;
  logic                  dir_q, seen_q, err_width_q, err_dir_q, stopped_q;
  logic [IDLE_W-1:0]     idle_cnt, idle_nxt;

  assign dir_stable_now = dir_change ? '0 : dir_stable;
  assign dir_bad        = count && (dir_stable_now < DS_MAX);
  assign x_base         = bus.load ? bus.x_val : x_q;
  assign idle_nxt       = count ? '0 :
                          (idle_cnt < IDLE_MAX) ? idle_cnt + IDLE_W'(1) : idle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_step_d    <= 1'b0;
      s_dir_d     <= 1'b0;
      arm_cnt     <= 2'd0;
      dir_stable  <= '0;
      x_q         <= '0;
      dir_q       <= 1'b0;
      seen_q      <= 1'b0;
      err_width_q <= 1'b0;
      err_dir_q   <= 1'b0;
      idle_cnt    <= '0;
      stopped_q   <= 1'b1;
    end else begin
      s_step_d    <= s_step;
      s_dir_d     <= s_dir;
      if (arm_cnt != 2'd2) arm_cnt <= arm_cnt + 2'd1;
      dir_stable  <= (dir_stable_now < DS_MAX) ? dir_stable_now + DS_W'(1) : dir_stable_now;
      x_q         <= count ? x_base + step_delta(s_dir) : x_base;
      if (count) dir_q <= s_dir;
      seen_q      <= count;
      // a new error in the same cycle as clear_err wins
      err_width_q <= width_bad | (err_width_q & ~bus.clear_err);
      err_dir_q   <= dir_bad   | (err_dir_q   & ~bus.clear_err);
      idle_cnt    <= idle_nxt;
      stopped_q   <= count ? 1'b0 : (stopped_q | (idle_nxt == IDLE_MAX));
    end
  end

`ifdef STEP_PERIOD_EN
  // Counter restarts at 1 on the counting edge so that rises N cycles apart
  // report period = N.
  logic [PERIOD_W-1:0] per_cnt, period_q;
  logic                period_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      if (count)                per_cnt <= PERIOD_W'(1);
      else if (per_cnt != '1)   per_cnt <= per_cnt + PERIOD_W'(1);
      if (count) begin
        period_q       <= per_cnt;
        period_valid_q <= ~stopped_q;
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
`else
  assign bus.period       = '0;
  assign bus.period_valid = 1'b0;
`endif

  assign bus.x         = x_q;
  assign bus.dir       = dir_q;
  assign bus.step_seen = seen_q;
  assign bus.err_width = err_width_q;
  assign bus.err_dir   = err_dir_q;
  assign bus.stopped   = stopped_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Self-checking bench for step_dir_decoder: directed scenarios plus random
// step/dir/load/clear traffic against a behavioural model of the pin rules.
module tb_step_dir_decoder;
  import step_if_pkg::*;

  localparam int MIN_HIGH     = 4;
  localparam int DIR_SETUP    = 8;
  localparam int IDLE_TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  step_dir_decoder_if bus();

  step_dir_decoder #(
    .MIN_HIGH(MIN_HIGH),
    .DIR_SETUP(DIR_SETUP),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  longint last_seen_cyc = 0;
  int     seen_cnt = 0;
  bit     rand_en  = 1'b0;
  bit     started  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on pin samples: each cycle's synchronized value is the pin sample
  // from two clocks earlier. A rise is counted whenever its preceding low
  // sample was taken after reset release.
  bit samp_s[$], samp_d[$];
  bit m_sprev, m_dprev, m_in_pulse;
  int m_t, m_last_change, m_last_step, m_pulse_start;
  logic signed [63:0] m_x;
  bit m_dir, m_seen, m_ew, m_ed, m_stopped, m_pv;
  logic [31:0] m_period;
  logic [63:0] exp_q[$];

  task automatic model_cycle();
    bit sc, dc, rise, fall, bad_w, bad_d;
    if (reset) begin
      samp_s = {1'b0, 1'b0};
      samp_d = {1'b0, 1'b0};
      m_sprev = 0; m_dprev = 0; m_in_pulse = 0;
      m_t = 0; m_last_change = 0; m_last_step = -1; m_pulse_start = 0;
      m_x = '0; m_dir = 0; m_seen = 0; m_ew = 0; m_ed = 0;
      m_stopped = 1; m_period = '0; m_pv = 0;
      exp_q.delete();
    end else begin
      samp_s.push_back(bus.step_in);
      samp_d.push_back(bus.dir_in);
      sc = samp_s.pop_front();
      dc = samp_d.pop_front();
      if (dc != m_dprev) m_last_change = m_t;
      rise  = sc && !m_sprev && (m_t >= 3);
      fall  = m_in_pulse && !sc;
      bad_w = fall && ((m_t - m_pulse_start) < MIN_HIGH);
      bad_d = rise && ((m_t - m_last_change) < DIR_SETUP);
      if (fall) m_in_pulse = 0;
      if (rise) begin m_in_pulse = 1; m_pulse_start = m_t; end
      m_ew   = bad_w | (m_ew & !bus.clear_err);
      m_ed   = bad_d | (m_ed & !bus.clear_err);
      m_seen = rise;
`ifdef STEP_PERIOD_EN
      if (rise) begin
        m_period = 32'((m_last_step >= 0) ? (m_t - m_last_step) : m_t);
        m_pv     = !m_stopped;
      end
`endif
      if (bus.load) m_x = bus.x_val;
      if (rise) begin
        m_x = m_x + (dc ? 64'sd1 : -64'sd1);
        m_dir = dc;
        m_last_step = m_t;
        exp_q.push_back(m_x);
      end
      m_stopped = (m_last_step < 0) || ((m_t - m_last_step) >= IDLE_TIMEOUT);
      m_sprev = sc;
      m_dprev = dc;
      m_t++;
    end
    started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_cycle();
  end

  // ---------------- compare process + scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("x",            bus.x,            m_x);
      chk("dir",          bus.dir,          m_dir);
      chk("step_seen",    bus.step_seen,    m_seen);
      chk("err_width",    bus.err_width,    m_ew);
      chk("err_dir",      bus.err_dir,      m_ed);
      chk("stopped",      bus.stopped,      m_stopped);
      chk("period",       bus.period,       m_period);
      chk("period_valid", bus.period_valid, m_pv);
      if (bus.step_seen === 1'b1) begin
        seen_cnt++;
        last_seen_cyc = cyc;
        if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else                   chk("sb_step_x", bus.x, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (rand_en) begin
      bus.load      = ($urandom_range(0, 19) == 0);
      bus.x_val     = {$urandom(), $urandom()};
      bus.clear_err = ($urandom_range(0, 14) == 0);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.step_in = 1'b1;
    repeat (hi) tick();
    bus.step_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic clear_errors();
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    bit got_stop;
    bus.step_in = 1'b0; bus.dir_in = 1'b1; bus.load = 1'b0;
    bus.x_val = '0; bus.clear_err = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_x",       bus.x,         64'd0);
    chk("rst_dir",     bus.dir,       64'd0);
    chk("rst_seen",    bus.step_seen, 64'd0);
    chk("rst_errw",    bus.err_width, 64'd0);
    chk("rst_stopped", bus.stopped,   64'd1);
    reset = 1'b0;
    repeat (12) tick();

    // 1: ten positive steps
    s0 = seen_cnt;
    repeat (10) pulse(6, 6);
    chk("t1_x",     bus.x,             64'd10);
    chk("t1_pulses", 64'(seen_cnt - s0), 64'd10);
    chk("t1_errw",  bus.err_width,     64'd0);
    chk("t1_errd",  bus.err_dir,       64'd0);
    chk("t1_dir",   bus.dir,           64'd1);

    // 2: three negative steps, then idle until stopped
    bus.dir_in = 1'b0;
    repeat (20) tick();
    repeat (3) pulse(6, 6);
    chk("t2_x", bus.x, 64'd7);
    got_stop = 1'b0;
    for (int k = 0; k < IDLE_TIMEOUT + 40 && !got_stop; k++) begin
      if (bus.stopped === 1'b1) got_stop = 1'b1;
      else tick();
    end
    chk("t2_stop_flag",  bus.stopped, 64'd1);
    chk("t2_stop_delay", 64'(cyc - last_seen_cyc), 64'(IDLE_TIMEOUT));

    // 3: short high pulse
    bus.dir_in = 1'b1;
    repeat (12) tick();
    pulse(2, 8);
    chk("t3_x",    bus.x,         64'd8);
    chk("t3_errw", bus.err_width, 64'd1);
    clear_errors();
    chk("t3_errw_clr", bus.err_width, 64'd0);

    // 4: dir changes only three cycles before the rise
    bus.dir_in = 1'b0;
    repeat (3) tick();
    pulse(6, 6);
    chk("t4_x",    bus.x,       64'd7);
    chk("t4_errd", bus.err_dir, 64'd1);
    chk("t4_dir",  bus.dir,     64'd0);
    clear_errors();
    chk("t4_errd_clr", bus.err_dir, 64'd0);

    // 5: load coinciding with the synchronized rise
    bus.dir_in = 1'b1;
    repeat (12) tick();
    bus.step_in = 1'b1;
    tick();
    tick();
    bus.load = 1'b1;
    bus.x_val = -64'sd5;
    tick();
    chk("t5_x",    bus.x,         -64'sd4);
    chk("t5_seen", bus.step_seen, 64'd1);
    bus.load = 1'b0;
    repeat (3) tick();
    bus.step_in = 1'b0;
    repeat (8) tick();

    // 6: step high across reset release, then two steps 100 cycles apart
    bus.step_in = 1'b1;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    s0 = seen_cnt;
    repeat (10) tick();
    chk("t6_x_held",     bus.x,               64'd0);
    chk("t6_no_pulse",   64'(seen_cnt - s0),  64'd0);
    bus.step_in = 1'b0;
    repeat (6) tick();
    bus.step_in = 1'b1;
    repeat (4) tick();
    chk("t6_x_first", bus.x, 64'd1);
    chk("t6_pv_first", bus.period_valid, 64'd0);
    repeat (2) tick();
    bus.step_in = 1'b0;
    repeat (94) tick();
    bus.step_in = 1'b1;
    repeat (4) tick();
    chk("t6_x_second", bus.x, 64'd2);
`ifdef STEP_PERIOD_EN
    chk("t6_period", bus.period,       64'd100);
    chk("t6_pv",     bus.period_valid, 64'd1);
`else
    chk("t6_period_off", bus.period,       64'd0);
    chk("t6_pv_off",     bus.period_valid, 64'd0);
`endif
    repeat (2) tick();
    bus.step_in = 1'b0;
    repeat (6) tick();

    // random traffic with strobes, short pulses, dir flips, idles and a reset
    rand_en = 1'b1;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) bus.dir_in = ~bus.dir_in;
      repeat ($urandom_range(0, 10)) tick();
      pulse($urandom_range(1, 8), $urandom_range(1, 10));
      if (i % 50 == 49) repeat (IDLE_TIMEOUT + $urandom_range(0, 40)) tick();
      if (i == 100) begin
        bus.step_in = 1'b1;
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bus.step_in = 1'b0;
        tick();
      end
    end
    rand_en = 1'b0;
    bus.load = 1'b0;
    bus.clear_err = 1'b0;
    repeat (10) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
